// File: rtl/ila_ctrl_pkg.sv
// ila_ctrl_pkg: state encoding shared by the ILA capture sequencer.
package ila_ctrl_pkg;
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_PRE  = 2'd1;
    localparam logic [STATE_W-1:0] ST_POST = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;
    typedef enum logic [STATE_W-1:0] {
        IDLE = ST_IDLE,
        PRE  = ST_PRE,
        POST = ST_POST,
        DONE = ST_DONE
    } state_e;
endpackage

// File: rtl/ila_capture_trig_match.sv
// ila_trig_match: masked value compare with optional rising-edge qualification.
// Ports: clk_i/arst_i clock and async reset; trig_mask_i/trig_val_i/trig_edge_i
// trigger config; sample_i probe word; hit_o trigger condition this cycle.
module ila_trig_match #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic [W-1:0] trig_mask_i,
    input  logic [W-1:0] trig_val_i,
    input  logic         trig_edge_i,
    input  logic [W-1:0] sample_i,
    output logic         hit_o
);
    logic match, match_prev_q;
    assign match = ((sample_i ^ trig_val_i) & trig_mask_i) == '0;
    assign hit_o = trig_edge_i ? (match & ~match_prev_q) : match;
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) match_prev_q <= 1'b0;
        else        match_prev_q <= match;
    end
endmodule

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: ILA capture sequencer driving the circular sample buffer write port.
// Ports: clk_i/arst_i clock and async reset; arm_i/abort_i control pulses;
// trig_* trigger config; post_cnt_i post-trigger sample count; sample_i probe word;
// buf_we_o/buf_addr_o/buf_data_o registered buffer write; trig_addr_o trigger sample
// address; wrapped_o pointer wrapped since arm; done_o capture complete; state_o state.
module ila_capture_ctrl
    import ila_ctrl_pkg::*;
#(
    parameter int W      = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [W-1:0]      trig_mask_i,
    input  logic [W-1:0]      trig_val_i,
    input  logic              trig_edge_i,
    input  logic [ADDR_W-1:0] post_cnt_i,
    input  logic [W-1:0]      sample_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [W-1:0]      buf_data_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              wrapped_o,
    output logic              done_o,
    output logic [STATE_W-1:0] state_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, trig_q, trig_d, addr_q;
    logic [W-1:0]      data_q;
    logic              wrap_q, wrap_d, done_q, we_q, wr, hit;

    ila_trig_match #(.W(W)) u_match (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .trig_mask_i (trig_mask_i),
        .trig_val_i  (trig_val_i),
        .trig_edge_i (trig_edge_i),
        .sample_i    (sample_i),
        .hit_o       (hit)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        wrap_d  = wrap_q;
        wr      = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE || state_q == DONE) begin
            if (arm_i) begin
                state_d = PRE;
                ptr_d   = '0;
                wrap_d  = 1'b0;
            end
        end else begin
            wr     = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            wrap_d = wrap_q | (&ptr_q);
            if (state_q == PRE) begin
                if (hit) begin
                    trig_d  = ptr_q;
                    cnt_d   = post_cnt_i;
                    state_d = (post_cnt_i == '0) ? DONE : POST;
                end
            end else begin
                // the write made while the counter reads 1 is the last post sample
                cnt_d = cnt_q - ADDR_W'(1);
                if (cnt_q == ADDR_W'(1)) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            trig_q  <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            wrap_q  <= wrap_d;
            done_q  <= (state_d == DONE);
            we_q    <= wr;
            if (wr) begin
                addr_q <= ptr_q;
                data_q <= sample_i;
            end
        end
    end

    assign buf_we_o    = we_q;
    assign buf_addr_o  = addr_q;
    assign buf_data_o  = data_q;
    assign trig_addr_o = trig_q;
    assign wrapped_o   = wrap_q;
    assign done_o      = done_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: directed scenarios checked against a behavioural capture model.
module tb_ila_capture_ctrl;
    localparam int W = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          arst_i = 1'b0;
    logic          arm_i = 1'b0, abort_i = 1'b0, trig_edge_i = 1'b0;
    logic [W-1:0]  trig_mask_i = '0, trig_val_i = '0, sample_i = '0;
    logic [AW-1:0] post_cnt_i = '0;
    logic          buf_we_o, wrapped_o, done_o;
    logic [AW-1:0] buf_addr_o, trig_addr_o;
    logic [W-1:0]  buf_data_o;
    logic [1:0]    state_o;

    ila_capture_ctrl #(.W(W), .ADDR_W(AW)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .trig_mask_i (trig_mask_i),
        .trig_val_i  (trig_val_i),
        .trig_edge_i (trig_edge_i),
        .post_cnt_i  (post_cnt_i),
        .sample_i    (sample_i),
        .buf_we_o    (buf_we_o),
        .buf_addr_o  (buf_addr_o),
        .buf_data_o  (buf_data_o),
        .trig_addr_o (trig_addr_o),
        .wrapped_o   (wrapped_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    int wr_cnt = 0, last_addr = 0, last_data = 0, base = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: phase 0 idle, 1 filling, 2 post-trigger, 3 done
    int e_state = 0, ptr = 0, left = 0, e_trig = 0, e_addr = 0, e_data = 0;
    bit e_we = 0, e_wrap = 0, mprev = 0, m, h;

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            e_state <= 0; ptr <= 0; left <= 0; e_trig <= 0; e_wrap <= 0;
            e_we <= 0; e_addr <= 0; e_data <= 0; mprev <= 0;
        end else begin
            m = (((sample_i ^ trig_val_i) & trig_mask_i) == 0);
            h = trig_edge_i ? (m && !mprev) : m;
            mprev <= m;
            e_we <= 0;
            if (abort_i) e_state <= 0;
            else if (e_state == 0 || e_state == 3) begin
                if (arm_i) begin e_state <= 1; ptr <= 0; e_wrap <= 0; end
            end else begin
                e_we <= 1; e_addr <= ptr; e_data <= int'(sample_i);
                ptr <= (ptr + 1) % DEPTH;
                if (ptr == DEPTH - 1) e_wrap <= 1;
                if (e_state == 1) begin
                    if (h) begin
                        e_trig <= ptr;
                        left <= int'(post_cnt_i);
                        e_state <= (post_cnt_i == 0) ? 3 : 2;
                    end
                end else begin
                    left <= left - 1;
                    if (left == 1) e_state <= 3;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        chk("we", int'(buf_we_o), int'(e_we));
        if (e_we) begin
            chk("addr", int'(buf_addr_o), e_addr);
            chk("data", int'(buf_data_o), e_data);
        end
        chk("trig_addr", int'(trig_addr_o), e_trig);
        chk("wrapped", int'(wrapped_o), int'(e_wrap));
        chk("done", int'(done_o), int'(e_state == 3));
        chk("state", int'(state_o), e_state);
        if (buf_we_o) begin
            wr_cnt++;
            last_addr = int'(buf_addr_o);
            last_data = int'(buf_data_o);
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        #1 arst_i = 1'b1;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_we", int'(buf_we_o), 0);
        chk("rst_done", int'(done_o), 0);
        step();
        arst_i = 1'b0;
        step();

        // level trigger
        trig_mask_i = 8'hFF; trig_val_i = 8'h5A; trig_edge_i = 0; post_cnt_i = 3;
        base = wr_cnt;
        arm_i = 1; sample_i = 8'h50; step(); arm_i = 0;
        for (int k = 1; k <= 20; k++) begin sample_i = 8'(8'h50 + k); step(); end
        chk("t1_trig", int'(trig_addr_o), 9);
        chk("t1_done", int'(done_o), 1);
        chk("t1_count", wr_cnt - base, 13);
        chk("t1_last_addr", last_addr, 12);
        chk("t1_last_data", last_data, 8'h5D);

        // rising-edge trigger with sample already matching at arm
        trig_edge_i = 1; post_cnt_i = 1; sample_i = 8'h5A; step();
        base = wr_cnt;
        arm_i = 1; step(); arm_i = 0;
        repeat (5) step();
        sample_i = 8'h00; step();
        sample_i = 8'h5A; step();
        sample_i = 8'h33; step();
        repeat (3) step();
        chk("t2_trig", int'(trig_addr_o), 6);
        chk("t2_count", wr_cnt - base, 8);
        chk("t2_last_addr", last_addr, 7);
        chk("t2_last_data", last_data, 8'h33);

        // wrap: trigger on the 20th pre sample
        trig_edge_i = 0; trig_val_i = 8'hC3; post_cnt_i = 2; sample_i = 8'h00;
        base = wr_cnt;
        arm_i = 1; step(); arm_i = 0;
        for (int k = 0; k < 19; k++) begin sample_i = 8'(k); step(); end
        sample_i = 8'hC3; step();
        sample_i = 8'h10; step();
        sample_i = 8'h11; step();
        sample_i = 8'h12; repeat (3) step();
        chk("t3_wrapped", int'(wrapped_o), 1);
        chk("t3_trig", int'(trig_addr_o), 3);
        chk("t3_last_addr", last_addr, 5);
        chk("t3_count", wr_cnt - base, 22);

        // post = 0 with empty mask
        trig_mask_i = 8'h00; post_cnt_i = 0; sample_i = 8'h99;
        base = wr_cnt;
        arm_i = 1; step(); arm_i = 0;
        sample_i = 8'h98; step();
        sample_i = 8'h97; repeat (3) step();
        chk("t4_count", wr_cnt - base, 1);
        chk("t4_last_addr", last_addr, 0);
        chk("t4_last_data", last_data, 8'h98);
        chk("t4_state", int'(state_o), 3);
        chk("t4_wrapped", int'(wrapped_o), 0);

        // abort in POST after one of four post writes
        trig_mask_i = 8'hFF; trig_val_i = 8'h77; post_cnt_i = 4; sample_i = 8'h01;
        base = wr_cnt;
        arm_i = 1; step(); arm_i = 0;
        step();
        sample_i = 8'h77; step();
        sample_i = 8'h02; step();
        abort_i = 1; sample_i = 8'h03; step(); abort_i = 0;
        repeat (5) step();
        chk("t5_count", wr_cnt - base, 3);
        chk("t5_state", int'(state_o), 0);
        chk("t5_done", int'(done_o), 0);
        chk("t5_we", int'(buf_we_o), 0);
        base = wr_cnt;
        arm_i = 1; step(); arm_i = 0;
        sample_i = 8'h44; step();
        chk("t5_rearm_count", wr_cnt - base, 1);
        chk("t5_rearm_addr", last_addr, 0);
        chk("t5_rearm_wrapped", int'(wrapped_o), 0);
        chk("t5_rearm_state", int'(state_o), 1);

        // asynchronous reset mid-PRE
        step();
        @(posedge clk_i);
        #2 arst_i = 1'b1;
        #1;
        chk("t6_we", int'(buf_we_o), 0);
        chk("t6_addr", int'(buf_addr_o), 0);
        chk("t6_data", int'(buf_data_o), 0);
        chk("t6_trig", int'(trig_addr_o), 0);
        chk("t6_state", int'(state_o), 0);
        step();
        arst_i = 1'b0;
        base = wr_cnt;
        step();
        chk("t6_after_count", wr_cnt - base, 0);
        chk("t6_after_state", int'(state_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
